// File: rtl/config_master_pkg.sv
// Shared constants for the config master: address-type codes, register offsets
// and the FSM state encoding.
package config_master_pkg;

    localparam logic [2:0] ATYPE_CFG_REG = 3'b000;
    localparam logic [2:0] ATYPE_WGT_MEM = 3'b001;
    localparam logic [2:0] ATYPE_DST_MEM = 3'b010;
    localparam logic [2:0] ATYPE_VM_MEM  = 3'b100;
    localparam logic [2:0] ATYPE_VM_BUF  = 3'b110;

    localparam logic [3:0] REG_STATUS    = 4'h0;
    localparam logic [3:0] REG_RAND_SEED = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_CAPT  = 3'd3,
        ST_RD_WAIT  = 3'd4
    } cm_state_t;

endpackage

// File: rtl/config_master_if.sv
// Command / response / config-port bundle for config_master.
// master = the config_master side, slave = the command source and config target.
interface config_master_if #(
    parameter int CDW  = 21,
    parameter int CAW  = 15,
    parameter int LENW = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_wr;
    logic [CAW-1:0]  cmd_addr;
    logic [CDW-1:0]  cmd_wdata;
    logic [LENW-1:0] cmd_len;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [CDW-1:0]  rsp_data;
    logic [CAW-1:0]  rsp_addr;
    logic            rsp_last;

    logic            config_we;
    logic [CAW-1:0]  config_waddr;
    logic [CDW-1:0]  config_wdata;
    logic            config_re;
    logic [CAW-1:0]  config_raddr;
    logic [CDW-1:0]  config_rdata;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_len, rsp_ready, config_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last,
               config_we, config_waddr, config_wdata, config_re, config_raddr
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_len, rsp_ready, config_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last,
               config_we, config_waddr, config_wdata, config_re, config_raddr
    );

endinterface

// File: rtl/config_master.sv
// Config-space master: turns write/read burst commands into config strobes.
// Bursts (cmd_len) are honoured only when CONFIG_MASTER_BURST_EN is defined.
module config_master
    import config_master_pkg::*;
#(
    parameter int CDW  = 21,
    parameter int CAW  = 15,
    parameter int ATW  = 3,
    parameter int LENW = 4
) (
    input  logic            clk,
    input  logic            rst,
    config_master_if.master bus,
    output logic            busy
);

    localparam int LW = CAW - ATW;

    cm_state_t       r_state, w_state_nxt;
    logic [CAW-1:0]  r_addr, w_addr_nxt, w_addr_inc;
    logic            r_we, w_we_nxt;
    logic [CAW-1:0]  r_waddr, w_waddr_nxt;
    logic [CDW-1:0]  r_wdata, w_wdata_nxt;
    logic            r_re, w_re_nxt;
    logic [CAW-1:0]  r_raddr, w_raddr_nxt;
    logic            r_rsp_valid, w_rsp_valid_nxt;
    logic [CDW-1:0]  r_rsp_data, w_rsp_data_nxt;
    logic [CAW-1:0]  r_rsp_addr, w_rsp_addr_nxt;
    logic            r_rsp_last, w_rsp_last_nxt;
    logic            w_cmd_ready;
    logic            w_last;
    logic            w_accept;

    // Only the low region bits advance; the type field is pinned.
    assign w_addr_inc = {r_addr[CAW-1:LW], r_addr[LW-1:0] + LW'(1)};

`ifdef CONFIG_MASTER_BURST_EN
    logic [LENW-1:0] r_len, w_len_nxt;
    logic [LENW-1:0] r_beat, w_beat_nxt;

    assign w_last = (r_beat == r_len);

    always_comb begin
        w_len_nxt  = r_len;
        w_beat_nxt = r_beat;
        if (w_accept) begin
            w_len_nxt  = bus.cmd_len;
            w_beat_nxt = '0;
        end else if ((r_state == ST_WR && !w_last) ||
                     (r_state == ST_RD_WAIT && bus.rsp_ready && !w_last)) begin
            w_beat_nxt = r_beat + LENW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len  <= '0;
            r_beat <= '0;
        end else begin
            r_len  <= w_len_nxt;
            r_beat <= w_beat_nxt;
        end
    end
`else
    logic [LENW-1:0] w_unused_len;

    assign w_unused_len = bus.cmd_len;
    assign w_last       = 1'b1;
`endif

    assign w_cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_we_nxt        = 1'b0;
        w_waddr_nxt     = r_waddr;
        w_wdata_nxt     = r_wdata;
        w_re_nxt        = 1'b0;
        w_raddr_nxt     = r_raddr;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_addr_nxt  = r_rsp_addr;
        w_rsp_last_nxt  = r_rsp_last;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_addr_nxt = bus.cmd_addr;
                    if (bus.cmd_wr) begin
                        w_state_nxt = ST_WR;
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = bus.cmd_addr;
                        w_wdata_nxt = bus.cmd_wdata;
                    end else begin
                        w_state_nxt = ST_RD_ISSUE;
                        w_re_nxt    = 1'b1;
                        w_raddr_nxt = bus.cmd_addr;
                    end
                end
            end
            ST_WR: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = w_addr_inc;
                    w_waddr_nxt = w_addr_inc;
                end
            end
            ST_RD_ISSUE: begin
                w_state_nxt = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                w_state_nxt     = ST_RD_WAIT;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = bus.config_rdata;
                w_rsp_addr_nxt  = r_addr;
                w_rsp_last_nxt  = w_last;
            end
            ST_RD_WAIT: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RD_ISSUE;
                        w_re_nxt    = 1'b1;
                        w_addr_nxt  = w_addr_inc;
                        w_raddr_nxt = w_addr_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_re        <= 1'b0;
            r_raddr     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_we        <= w_we_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_re        <= w_re_nxt;
            r_raddr     <= w_raddr_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
        end
    end

    assign bus.cmd_ready    = w_cmd_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_addr     = r_rsp_addr;
    assign bus.rsp_last     = r_rsp_last;
    assign bus.config_we    = r_we;
    assign bus.config_waddr = r_waddr;
    assign bus.config_wdata = r_wdata;
    assign bus.config_re    = r_re;
    assign bus.config_raddr = r_raddr;
    assign busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_config_master.sv
// Directed bench for config_master; expectations follow the burst macro
// CONFIG_MASTER_BURST_EN (single-beat when undefined).
module tb_config_master;

`ifdef CONFIG_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    config_master_if #(.CDW(21), .CAW(15), .LENW(4)) bus_if ();

    config_master #(.CDW(21), .CAW(15), .ATW(3), .LENW(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] model_rd(input logic [14:0] a);
        return {6'h15, a};
    endfunction

    function automatic logic [14:0] exp_addr(input logic [14:0] base, input int i);
        return {base[14:12], 12'(base[11:0] + 12'(i))};
    endfunction

    function automatic int nbeats(input logic [3:0] len);
        return BURST ? int'(len) + 1 : 1;
    endfunction

    // Config target: read data appears the cycle after config_re.
    always @(posedge clk) begin
        if (rst) bus_if.config_rdata <= '0;
        else if (bus_if.config_re) bus_if.config_rdata <= model_rd(bus_if.config_raddr);
    end

    int          cyc = 0;
    int          n_overlap = 0;
    int          n_stray = 0;
    logic [14:0] we_addr_q[$];
    logic [20:0] we_data_q[$];
    int          we_cyc_q[$];
    logic [14:0] re_q[$];
    int          hs_cyc_q[$];
    logic [14:0] hs_addr_q[$];
    logic [20:0] hs_data_q[$];
    logic        hs_last_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus_if.config_we) begin
                we_addr_q.push_back(bus_if.config_waddr);
                we_data_q.push_back(bus_if.config_wdata);
                we_cyc_q.push_back(cyc);
            end
            if (bus_if.config_re) re_q.push_back(bus_if.config_raddr);
            if (bus_if.config_we && bus_if.config_re) n_overlap <= n_overlap + 1;
            if ((bus_if.config_we || bus_if.config_re) && !busy) n_stray <= n_stray + 1;
            if (bus_if.rsp_valid && bus_if.rsp_ready) begin
                hs_cyc_q.push_back(cyc);
                hs_addr_q.push_back(bus_if.rsp_addr);
                hs_data_q.push_back(bus_if.rsp_data);
                hs_last_q.push_back(bus_if.rsp_last);
            end
        end
    end

    task automatic clear_logs();
        we_addr_q.delete(); we_data_q.delete(); we_cyc_q.delete(); re_q.delete();
        hs_cyc_q.delete(); hs_addr_q.delete(); hs_data_q.delete(); hs_last_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    task automatic wait_rsp(input int budget);
        int k = 0;
        while (!bus_if.rsp_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("rsp_valid_seen", 32'(bus_if.rsp_valid), 1);
    endtask

    task automatic send_cmd(input bit wr, input logic [14:0] addr, input logic [20:0] data,
                            input logic [3:0] len);
        @(negedge clk);
        check("cmd_ready_idle", 32'(bus_if.cmd_ready), 1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_wr    = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = data;
        bus_if.cmd_len   = len;
        @(posedge clk);
        #1 bus_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 1);
        check("strobe_after_accept", 32'(wr ? bus_if.config_we : bus_if.config_re), 1);
    endtask

    task automatic run_write(input logic [14:0] addr, input logic [20:0] data, input logic [3:0] len);
        int n = nbeats(len);
        clear_logs();
        send_cmd(1'b1, addr, data, len);
        wait_idle(40);
        check("we_count", 32'(we_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < we_addr_q.size(); i++) begin
            check("we_addr", 32'(we_addr_q[i]), 32'(exp_addr(addr, i)));
            check("we_data", 32'(we_data_q[i]), 32'(data));
            check("we_consecutive", 32'(we_cyc_q[i]), 32'(we_cyc_q[0] + i));
        end
        check("wr_no_re", 32'(re_q.size()), 0);
    endtask

    // Each beat is stalled for 'stall' cycles; a write command is offered
    // during the first stall and must be ignored.
    task automatic run_read_stall(input logic [14:0] addr, input logic [3:0] len, input int stall);
        int n = nbeats(len);
        logic [14:0] ea;
        clear_logs();
        bus_if.rsp_ready = 1'b0;
        send_cmd(1'b0, addr, '0, len);
        for (int b = 0; b < n; b++) begin
            wait_rsp(20);
            ea = exp_addr(addr, b);
            check("rsp_addr", 32'(bus_if.rsp_addr), 32'(ea));
            check("rsp_data", 32'(bus_if.rsp_data), 32'(model_rd(ea)));
            check("rsp_last", 32'(bus_if.rsp_last), 32'(b == n - 1));
            for (int s = 0; s < stall; s++) begin
                if (b == 0 && s == 0) begin
                    bus_if.cmd_valid = 1'b1;
                    bus_if.cmd_wr    = 1'b1;
                    bus_if.cmd_addr  = 15'h7777;
                    bus_if.cmd_wdata = 21'h1F00F;
                    bus_if.cmd_len   = 4'd0;
                end
                @(negedge clk);
                check("stall_valid", 32'(bus_if.rsp_valid), 1);
                check("stall_addr", 32'(bus_if.rsp_addr), 32'(ea));
                check("stall_data", 32'(bus_if.rsp_data), 32'(model_rd(ea)));
                check("stall_last", 32'(bus_if.rsp_last), 32'(b == n - 1));
                check("busy_cmd_ready", 32'(bus_if.cmd_ready), 0);
            end
            bus_if.cmd_valid = 1'b0;
            bus_if.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus_if.rsp_ready = 1'b0;
            @(negedge clk);
            check("rsp_valid_drop", 32'(bus_if.rsp_valid), 0);
        end
        wait_idle(40);
        check("re_count", 32'(re_q.size()), 32'(n));
        for (int i = 0; i < n && i < re_q.size(); i++)
            check("re_addr", 32'(re_q[i]), 32'(exp_addr(addr, i)));
        check("ignored_cmd_no_we", 32'(we_addr_q.size()), 0);
    endtask

    task automatic run_read_fast(input logic [14:0] addr, input logic [3:0] len);
        int n = nbeats(len);
        clear_logs();
        bus_if.rsp_ready = 1'b1;
        send_cmd(1'b0, addr, '0, len);
        wait_idle(60);
        bus_if.rsp_ready = 1'b0;
        check("fast_rsp_count", 32'(hs_cyc_q.size()), 32'(n));
        for (int i = 0; i < n && i < hs_cyc_q.size(); i++) begin
            check("fast_addr", 32'(hs_addr_q[i]), 32'(exp_addr(addr, i)));
            check("fast_data", 32'(hs_data_q[i]), 32'(model_rd(exp_addr(addr, i))));
            check("fast_last", 32'(hs_last_q[i]), 32'(i == n - 1));
            if (i > 0) check("fast_period", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_wr    = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_wdata = '0;
        bus_if.cmd_len   = '0;
        bus_if.rsp_ready = 1'b0;

        // Reset state, sampled while rst is still high.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus_if.cmd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
        check("rst_rsp_last", 32'(bus_if.rsp_last), 0);
        check("rst_rsp_data", 32'(bus_if.rsp_data), 0);
        check("rst_rsp_addr", 32'(bus_if.rsp_addr), 0);
        check("rst_we", 32'(bus_if.config_we), 0);
        check("rst_re", 32'(bus_if.config_re), 0);
        check("rst_waddr", 32'(bus_if.config_waddr), 0);
        check("rst_wdata", 32'(bus_if.config_wdata), 0);
        check("rst_raddr", 32'(bus_if.config_raddr), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(bus_if.cmd_ready), 1);

        run_write(15'h0001, 21'h00ABC, 4'd0);
        repeat (3) @(negedge clk);
        check("hold_waddr", 32'(bus_if.config_waddr), 32'h0001);
        check("hold_wdata", 32'(bus_if.config_wdata), 32'h00ABC);

        run_write(15'h4000, 21'h00000, 4'd15);
        // 0x1FFE has type 001; the burst wraps to 0x1000 inside that region.
        run_write(15'h1FFE, 21'h15A5A, 4'd3);

        run_read_stall(15'h2000, 4'd2, 5);
        check("read_keeps_wdata", 32'(bus_if.config_wdata), 32'h15A5A);
        check("hold_raddr", 32'(bus_if.config_raddr), 32'(exp_addr(15'h2000, nbeats(4'd2) - 1)));

        run_read_fast(15'h4FFE, 4'd3);
        run_read_stall(15'h0005, 4'd7, 1);

        // Reset while a response is pending.
        clear_logs();
        bus_if.rsp_ready = 1'b0;
        send_cmd(1'b0, 15'h6010, '0, 4'd2);
        wait_rsp(20);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", 32'(bus_if.rsp_valid), 0);
        check("abort_rsp_data", 32'(bus_if.rsp_data), 0);
        check("abort_re", 32'(bus_if.config_re), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_cmd_ready", 32'(bus_if.cmd_ready), 1);
        repeat (8) @(negedge clk);
        check("abort_re_count", 32'(re_q.size()), 1);
        check("abort_no_rsp", 32'(bus_if.rsp_valid), 0);

        check("we_re_overlap", 32'(n_overlap), 0);
        check("strobe_outside_busy", 32'(n_stray), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
